ospfb_phase_comp: RTL and testbench
===================================

// Module: ospfb_phase_comp
// PURPOSE
//  Oversampled-PFB phase compensation stage: sits between the polyphase FIR output and the FFT.
//  Buffers each FFT_LEN-sample frame in a ping-pong RAM and replays it circularly rotated by
//  s_n = (n*DEC_FAC) mod FFT_LEN samples, so frame n enters the FFT phase-aligned.
//  Operates on SAMP_PER_CLK samples per word; all shifts are whole words.
// PARAMETERS
//  WIDTH         16    bits per sample
//  SAMP_PER_CLK  2     samples per AXI word
//  FFT_LEN       2048  M, samples per frame (divisible by SAMP_PER_CLK)
//  DEC_FAC       1536  D, decimation factor (divisible by SAMP_PER_CLK)
//  derived: L = FFT_LEN/SAMP_PER_CLK words/frame; STEP = DEC_FAC/SAMP_PER_CLK words
// PORTS
//  clk            in   1                   single clock, all logic rising-edge
//  rst_n          in   1                   asynchronous, active-low reset
//  s_axis_tdata   in   SAMP_PER_CLK*WIDTH  FIR output word, sample 0 in LSBs
//  s_axis_tvalid  in   1                   input valid
//  s_axis_tlast   in   1                   marks word L-1 of input frame
//  s_axis_tready  out  1                   input ready
//  m_axis_tdata   out  SAMP_PER_CLK*WIDTH  rotated word to FFT
//  m_axis_tvalid  out  1                   output valid
//  m_axis_tlast   out  1                   marks word L-1 of output frame
//  m_axis_tready  in   1                   FFT ready
//  shift_words    out  $clog2(L)           rotation of frame currently being output
//  frame_err      out  1                   sticky: s_axis_tlast misaligned with word count
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0 (s_axis_tready 0 during reset, 1 one cycle
//   after release); both banks FREE; wr_bank=rd_bank=0; wr/rd counters 0; shift accumulator 0.
//  Reset mid-frame discards all buffered/partial data; no output beats for discarded frames.
//  Banks: 2 x L words, each flag FREE or FULL.
//  Write: s_axis_tready = (bank[wr_bank]==FREE). Beat accepted on tvalid&tready, written at
//   wr_cnt; wr_cnt==L-1 -> bank FULL, wr_bank toggles, wr_cnt=0.
//  Framing by count only; tlast ignored for framing. tlast!=(wr_cnt==L-1) on an accepted beat
//   sets frame_err (cleared only by reset).
//  Read: when bank[rd_bank]==FULL, output word i (i=0..L-1) = stored word (i+shift) mod L.
//   tlast on i==L-1. After that beat is accepted: bank FREE, rd_bank toggles,
//   shift = (shift+STEP) mod L (wrap by subtract, no divider).
//  shift_words valid and stable for the whole output frame.
//  Arithmetic: shift and read address are modulo-L adds on $clog2(L) bits with compare-subtract;
//   L need not be a power of 2. Sample-level data passes unmodified.
//  Latency: first output beat valid <=3 cycles after the last input word of a frame is accepted,
//   provided the read side is idle.
//  Throughput: 1 word/cycle sustained on both sides when m_axis_tready=1.
//  AXI rules: m_axis_tdata/tlast stable while tvalid&!tready; tvalid never drops without a
//   handshake. RAM read latency (1 cycle) hidden by prefetch plus 2-entry output skid buffer.
//   No bubbles under continuous tready.
//  Simultaneous: a write completing and a read freeing the same cycle are both honoured, same or
//   other bank. Both banks FULL -> s_axis_tready=0 until a read frees one.
//  Empty: m_axis_tvalid=0; no spurious tlast.
// TESTING (use FFT_LEN=16, DEC_FAC=12, SPC=2 -> L=8, STEP=6)
//  1 Frames f=0..4 of ramp words 10f+k (k=0..7), tready=1 -> frame rotations 0,6,4,2,0.
//    Frame 1 out: 16,17,10,11,12,13,14,15. tlast on 8th beat each frame; frame_err=0.
//  2 Random m_axis_tready (50%) over 20 frames -> no loss/dup; data equals scoreboard rotation;
//    tdata stable while stalled.
//  3 tready=0 held, 3 frames offered -> 2 accepted, s_axis_tready=0 on 17th word;
//    after release, frame 3 accepted and all output in order.
//  4 Continuous in/out, tready=1 -> no s or m bubbles after first frame;
//    first m beat <=3 cycles after input word 7.
//  5 tlast asserted on word 5 of frame 0 -> frame_err=1 stays; framing and output unaffected.
//  6 rst_n pulsed low mid-frame 2 -> outputs 0 immediately; after release, next frame
//    output with shift 0.

Source files
------------

// File: rtl/ospfb_phase_comp.sv
// Oversampled-PFB phase compensation stage.
// Each L-word frame from the polyphase FIR is captured in one half of a
// ping-pong RAM. It is then replayed circularly rotated by s_n = (n*STEP) mod L
// words, so that frame n reaches the FFT phase-aligned. The read path prefetches
// through a 1-cycle RAM and a 2-entry skid FIFO. This gives one word per cycle
// with full AXI-Stream backpressure.
module ospfb_phase_comp #(
    parameter int WIDTH        = 16,
    parameter int SAMP_PER_CLK = 2,
    parameter int FFT_LEN      = 2048,
    parameter int DEC_FAC      = 1536
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [SAMP_PER_CLK*WIDTH-1:0]            s_axis_tdata,
    input  logic                                     s_axis_tvalid,
    input  logic                                     s_axis_tlast,
    output logic                                     s_axis_tready,
    output logic [SAMP_PER_CLK*WIDTH-1:0]            m_axis_tdata,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready,
    output logic [$clog2(FFT_LEN/SAMP_PER_CLK)-1:0]  shift_words,
    output logic                                     frame_err
);

    localparam int DW   = SAMP_PER_CLK * WIDTH;
    localparam int L    = FFT_LEN / SAMP_PER_CLK;
    localparam int STEP = DEC_FAC / SAMP_PER_CLK;
    localparam int AW   = $clog2(L);

    localparam logic [AW-1:0] LAST   = AW'(L - 1);
    localparam logic [AW-1:0] STEP_M = AW'(STEP % L);
    localparam logic [AW:0]   L_EXT  = (AW + 1)'(L);

    // Modulo-L add of two values already below L: one compare-subtract, no divider.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= L_EXT) sum = sum - L_EXT;
        return sum[AW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              ready_q;                  // holds s_axis_tready low through reset
    logic              wr_bank_q, wr_bank_d;
    logic [AW-1:0]     wr_cnt_q,  wr_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        full_q,    full_d;        // per-bank FULL flag
    logic              rd_bank_q, rd_bank_d;     // bank being fetched
    logic [AW-1:0]     rd_cnt_q,  rd_cnt_d;      // output index i of word being fetched
    logic [AW-1:0]     rd_shift_q, rd_shift_d;   // rotation of frame being fetched
    logic [AW-1:0]     shift_q,   shift_d;       // rotation of frame at the output port

    logic [DW-1:0]     mem [0:1][0:L-1];
    logic [DW-1:0]     rdata_q;
    logic              rlast_q;
    logic              pend_q;                   // a RAM read is landing in rdata_q

    logic [DW-1:0]     fifo_data_q [0:1];
    logic              fifo_last_q [0:1];
    logic              fifo_wp_q, fifo_rp_q;
    logic [1:0]        fifo_cnt_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          wr_fire, wr_last, wr_done;
    logic          rd_fire, rd_last, rd_done;
    logic          pop, pop_last;
    logic [2:0]    occ;
    logic [AW-1:0] rd_addr;

    assign s_axis_tready = ready_q & ~full_q[wr_bank_q];
    assign wr_fire       = s_axis_tvalid & s_axis_tready;
    assign wr_last       = (wr_cnt_q == LAST);
    assign wr_done       = wr_fire & wr_last;

    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[fifo_rp_q];
    assign m_axis_tlast  = fifo_last_q[fifo_rp_q] & m_axis_tvalid;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign pop_last      = pop & fifo_last_q[fifo_rp_q];

    assign shift_words   = shift_q;
    assign frame_err     = frame_err_q;

    // Words committed to the skid FIFO once this cycle settles; fetch only while room remains.
    assign occ     = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_fire = full_q[rd_bank_q] & (occ < 3'd2);
    assign rd_last = (rd_cnt_q == LAST);
    assign rd_done = rd_fire & rd_last;
    assign rd_addr = mod_add(rd_cnt_q, rd_shift_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Write side: count words into the current bank; tlast only feeds the error flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        frame_err_d = frame_err_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d  = wr_cnt_q + AW'(1);
            end
            if (s_axis_tlast != wr_last) frame_err_d = 1'b1;
        end
    end

    // Fetch side: walk i = 0..L-1, addressing stored word (i + shift) mod L.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_shift_d = rd_shift_q;
        if (rd_fire) begin
            if (rd_last) begin
                rd_cnt_d   = '0;
                rd_bank_d  = ~rd_bank_q;
                rd_shift_d = mod_add(rd_shift_q, STEP_M);
            end else begin
                rd_cnt_d   = rd_cnt_q + AW'(1);
            end
        end
    end

    // Bank flags. A bank is released as soon as its final word has been read:
    // its data is then fully held in the read pipeline, so the writer can
    // refill it without stalling. Write-complete and release never target
    // the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
    end

    // Reported rotation advances only when the output frame's tlast beat is taken.
    always_comb begin
        shift_d = shift_q;
        if (pop_last) shift_d = mod_add(shift_q, STEP_M);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Input ready comes up one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    // Control state for both sides of the ping-pong buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            frame_err_q <= 1'b0;
            full_q      <= 2'b00;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_shift_q  <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            rlast_q     <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            frame_err_q <= frame_err_d;
            full_q      <= full_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_shift_q  <= rd_shift_d;
            shift_q     <= shift_d;
            pend_q      <= rd_fire;
            if (rd_fire) rlast_q <= rd_last;
        end
    end

    // Frame RAM: one write port and one registered read port.
    always_ff @(posedge clk) begin
        // NOTE: the RAM and its read register carry no reset; the bank flags and pend_q decide what is valid.
        if (wr_fire) mem[wr_bank_q][wr_cnt_q] <= s_axis_tdata;
        if (rd_fire) rdata_q <= mem[rd_bank_q][rd_addr];
    end

    // Two-entry skid FIFO absorbing the RAM latency under output backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (pend_q) begin
                fifo_data_q[fifo_wp_q] <= rdata_q;
                fifo_last_q[fifo_wp_q] <= rlast_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ospfb_phase_comp.sv
// Self-checking bench for ospfb_phase_comp (FFT_LEN=16, DEC_FAC=12, SPC=2 -> L=8, STEP=6).
// A scoreboard holds the expected rotated beats; a negedge monitor compares every output handshake.
module tb_ospfb_phase_comp;

    localparam int WIDTH   = 16;
    localparam int SPC     = 2;
    localparam int FFT_LEN = 16;
    localparam int DEC_FAC = 12;
    localparam int L       = FFT_LEN / SPC;
    localparam int DW      = WIDTH * SPC;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [2:0]    shift_words;
    logic          frame_err;

    ospfb_phase_comp #(
        .WIDTH(WIDTH), .SAMP_PER_CLK(SPC), .FFT_LEN(FFT_LEN), .DEC_FAC(DEC_FAC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .shift_words(shift_words), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [2:0]    shift;
    } beat_t;

    // Frame-level vector: input frame index -> expected rotation and first output sample.
    typedef struct {
        int frame;
        int exp_shift;
        int exp_first;
    } t1_vec_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    int          cur_k = 0;
    int          m_beats, s_beats, first_m_cyc, last_m_cyc, first_s_cyc, last_s_cyc, word7_cyc;
    int          out_idx = 0;
    logic [15:0] last_frame [0:7];
    logic [2:0]  last_frame_shift;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rot(input int n);
        return ((n * DEC_FAC) % FFT_LEN) / SPC;
    endfunction

    function automatic logic [DW-1:0] mk_word(input int v);
        return {16'(v + 1000), 16'(v)};
    endfunction

    task automatic reset_stats();
        m_beats = 0; s_beats = 0;
        first_m_cyc = -1; last_m_cyc = -1;
        first_s_cyc = -1; last_s_cyc = -1;
        word7_cyc = -1;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output-side ready generator
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: handshakes seen at the negedge complete at the following posedge.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
            out_idx    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(m_tvalid), 64'd1);
                check("stall_data_held", 64'({m_tlast, m_tdata}), 64'({prev_last, prev_data}));
            end
            if (s_tvalid && s_tready) begin
                s_beats++;
                if (first_s_cyc < 0) first_s_cyc = cyc;
                last_s_cyc = cyc;
                if (cur_k == 7 && word7_cyc < 0) word7_cyc = cyc;
            end
            if (m_tvalid && first_m_cyc < 0) first_m_cyc = cyc;
            if (m_tvalid && m_tready) begin
                m_beats++;
                last_m_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got data %0h with empty scoreboard at %0t", m_tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_tdata), 64'(e.data));
                    check("beat_tlast", 64'(m_tlast), 64'(e.last));
                    check("beat_shift", 64'(shift_words), 64'(e.shift));
                end
                last_frame[out_idx] = m_tdata[15:0];
                if (m_tlast) begin
                    check("tlast_position", 64'(out_idx), 64'd7);
                    last_frame_shift = shift_words;
                    out_idx = 0;
                end else begin
                    out_idx = (out_idx + 1) % 8;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic send_word(input logic [DW-1:0] w, input logic last, input int k);
        int budget;
        s_tdata  = w;
        s_tlast  = last;
        s_tvalid = 1'b1;
        cur_k    = k;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            budget++;
            if (budget > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: word %0d not accepted within 300 cycles", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Sends ramp frame f; scoreboard expects it rotated by rot. bad_k >= 0 moves tlast to that word.
    task automatic send_frame(input int f, input int rot, input int bad_k);
        logic [DW-1:0] w [0:7];
        for (int k = 0; k < L; k++) w[k] = mk_word(10 * f + k);
        for (int i = 0; i < L; i++)
            exp_q.push_back('{data: w[(i + rot) % L], last: (i == L - 1), shift: 3'(rot)});
        for (int k = 0; k < L; k++)
            send_word(w[k], (bad_k < 0) ? (k == L - 1) : (k == bad_k), k);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        check("idle_tvalid", 64'(m_tvalid), 64'd0);
        check("idle_tlast", 64'(m_tlast), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_shift", 64'(shift_words), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 64'(s_tready), 64'd1);
        reset_stats();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t1_vec_t     t1 [0:4];
        logic [15:0] f1_exp [0:7];

        t1[0] = '{frame: 0, exp_shift: 0, exp_first: 0};
        t1[1] = '{frame: 1, exp_shift: 6, exp_first: 16};
        t1[2] = '{frame: 2, exp_shift: 4, exp_first: 24};
        t1[3] = '{frame: 3, exp_shift: 2, exp_first: 32};
        t1[4] = '{frame: 4, exp_shift: 0, exp_first: 40};
        f1_exp = '{16'd16, 16'd17, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15};

        rst_n = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        reset_stats();
        @(posedge clk);

        // 1: ramp frames, rotations 0,6,4,2,0
        apply_reset();
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(t1[i].frame, t1[i].exp_shift, -1);
            wait_drain(100);
            check("t1_frame_shift", 64'(last_frame_shift), 64'(t1[i].exp_shift));
            check("t1_first_sample", 64'(last_frame[0]), 64'(t1[i].exp_first));
            if (t1[i].frame == 1)
                for (int k = 0; k < 8; k++) check("t1_frame1_word", 64'(last_frame[k]), 64'(f1_exp[k]));
        end
        check("t1_beats", 64'(m_beats), 64'd40);
        check("t1_frame_err", 64'(frame_err), 64'd0);

        // 2: random output backpressure over 20 frames
        apply_reset();
        ready_mode = 1;
        for (int n = 0; n < 20; n++) send_frame(n, model_rot(n), -1);
        ready_mode = 0;
        wait_drain(2000);
        check("t2_beats", 64'(m_beats), 64'd160);

        // 3: output held off; only two frames fit
        apply_reset();
        ready_mode = 2;
        fork
            for (int n = 0; n < 3; n++) send_frame(n, model_rot(n), -1);
            begin
                repeat (60) @(posedge clk);
                #2;
                check("t3_accepted", 64'(s_beats), 64'd16);
                check("t3_s_tready_low", 64'(s_tready), 64'd0);
                check("t3_no_output", 64'(m_beats), 64'd0);
                ready_mode = 0;
            end
        join
        wait_drain(200);
        check("t3_beats", 64'(m_beats), 64'd24);
        check("t3_in_beats", 64'(s_beats), 64'd24);

        // 4: continuous streaming
        apply_reset();
        ready_mode = 0;
        for (int n = 0; n < 4; n++) send_frame(n, model_rot(n), -1);
        wait_drain(200);
        check("t4_s_beats", 64'(s_beats), 64'd32);
        check("t4_s_no_bubble", 64'(last_s_cyc - first_s_cyc), 64'd31);
        check("t4_m_beats", 64'(m_beats), 64'd32);
        check("t4_m_no_bubble", 64'(last_m_cyc - first_m_cyc), 64'd31);
        check("t4_first_latency_le3", 64'((first_m_cyc - word7_cyc) <= 3), 64'd1);

        // 5: tlast on word 5 of frame 0
        apply_reset();
        ready_mode = 0;
        send_frame(0, model_rot(0), 5);
        repeat (2) @(posedge clk);
        #1;
        check("t5_frame_err_set", 64'(frame_err), 64'd1);
        send_frame(1, model_rot(1), -1);
        repeat (4) @(posedge clk);
        #1;
        check("t5_frame_err_sticky", 64'(frame_err), 64'd1);

        // 6: reset mid-frame 2 while frame 1 is still streaming out
        for (int k = 0; k < 3; k++) send_word(mk_word(20 + k), 1'b0, k);
        check("t6_busy_before_reset", 64'(m_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6_rst_m_tdata", 64'(m_tdata), 64'd0);
        check("t6_rst_s_tready", 64'(s_tready), 64'd0);
        check("t6_rst_shift", 64'(shift_words), 64'd0);
        check("t6_rst_frame_err", 64'(frame_err), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        reset_stats();
        send_frame(7, 0, -1);
        wait_drain(100);
        check("t6_beats", 64'(m_beats), 64'd8);
        check("t6_shift_after_reset", 64'(last_frame_shift), 64'd0);
        check("t6_first_sample", 64'(last_frame[0]), 64'd70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
